kmkz_prefetch_buf: RTL and testbench
====================================

# kmkz_prefetch_buf

Parametrised instruction prefetch buffer for the Kamikaze-uRV fetch stage. It sits between instruction memory and the decoder. It issues word-aligned fetches, stores the returned words as halfword slots in a circular buffer, and presents 16-bit (compressed) or 32-bit instructions with their PC over a valid/ready handshake. Compared with the fixed 8-slot fetch FIFO it adds:
- configurable depth;
- a proper request/ack memory handshake;
- a decoder-side backpressure handshake;
- exact handling of 32-bit instructions straddling words;
- misaligned branch targets;
- an occupancy output.

## Interface
Parameters:
- DEPTH, 8, number of 16-bit slots; power of two, ≥ 4.
- RESET_PC, 32'h0000_0000, PC loaded at reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  32  fetch address; bits [1:0] are always 0.
- mem_ack_i  in  1  memory returns mem_data_i this cycle; valid only when mem_req_o=1.
- mem_data_i  in  32  fetched word; [15:0] is the lower-address halfword.
- instr_o  out  32  head instruction; bits [31:16] are don't-care when comp_o=1.
- comp_o  out  1  head instruction is compressed (head[1:0] != 2'b11).
- pc_o  out  32  PC of the head instruction.
- valid_o  out  1  a complete instruction is at the head.
- ready_i  in  1  decoder accepts the head instruction.
- branch_i  in  1  flush the buffer and redirect fetch.
- branch_pc_i  in  32  redirect target; bit 0 is ignored (treated as 0).
- level_o  out  $clog2(DEPTH)+1  number of occupied slots.

## Operation
- State:
  - halfword array buf[DEPTH];
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count, 0..DEPTH;
  - fetch_addr, word-aligned;
  - pc;
  - skip flag.
- Priority: rst_i > branch_i > normal operation.
- Reset:
  - count=0, rd_ptr=wr_ptr=0;
  - fetch_addr=RESET_PC&~3, pc=RESET_PC&~1;
  - skip=RESET_PC[1].
- Branch (branch_i=1):
  - same state assignments as reset, using branch_pc_i;
  - any mem_ack_i in that cycle is discarded;
  - any decoder pop in that cycle is discarded.
- Request:
  - mem_req_o = !rst_i && !branch_i && (count ≤ DEPTH-2);
  - mem_addr_o = fetch_addr;
  - mem_addr_o stays stable while mem_req_o is held without ack;
  - ack in the same cycle as req is legal (zero-wait, one word per cycle).
- Push (mem_req_o && mem_ack_i):
  - if skip=0: write buf[wr_ptr]=data[15:0], buf[wr_ptr+1]=data[31:16]; wr_ptr+=2; push_n=2;
  - if skip=1: the lower halfword is dropped. Write buf[wr_ptr]=data[31:16]; wr_ptr+=1; push_n=1; clear skip;
  - in both cases fetch_addr+=4.
- Head decode (combinational):
  - comp_o = buf[rd_ptr][1:0] != 2'b11;
  - instr_o = {buf[rd_ptr+1], buf[rd_ptr]};
  - valid_o = (count≥1 && comp_o) || count≥2;
  - valid_o is forced to 0 during rst_i or branch_i.
- Pop (valid_o && ready_i):
  - pop_n = comp_o ? 1 : 2;
  - rd_ptr += pop_n;
  - pc += 2*pop_n.
- Count update: count <= count + push_n - pop_n, so simultaneous push and pop are a single update.
- Straddle: a 32-bit instruction whose upper half is not yet fetched keeps valid_o=0 until the next push. It is never presented partially.
- Overflow: structurally impossible, because a push requires count ≤ DEPTH-2.
- Underflow: impossible, because a pop requires valid_o.

## Timing
- Outputs after reset and after a branch:
  - valid_o=0;
  - pc_o = target;
  - mem_req_o=1 in the first cycle after rst_i/branch_i deasserts;
  - level_o=0.
- Latency, zero-wait memory:
  - branch_i at cycle N;
  - req/ack at N+1;
  - valid_o at N+2.
- Throughput: one instruction per cycle with zero-wait memory. A sustained 32-bit stream needs one ack per cycle.
- Output timing:
  - instr_o, comp_o and valid_o are combinational from registered state (buffer plus pointers);
  - pc_o and level_o are registered.
- Wrap-around: pointers wrap silently. A straddling 32-bit instruction at slots DEPTH-1/0 is assembled correctly.

## Test plan
- Reset with RESET_PC=0x100 and zero-wait memory; memory returns words 0x00010013, 0x00000013, ... ->
  - mem_addr_o sequence is 0x100, 0x104, ...;
  - first valid_o is in the second cycle after reset deassertion;
  - instructions are 0x00010013 at pc 0x100, then 0x00000013 at pc 0x104.
- Mixed stream: words 0x0013_4501 (c.li at 0x0, then the lower half of a 32-bit instruction), then 0x4581_0000 ->
  - 0x4501 comp_o=1 at pc 0x0;
  - 32-bit 0x00000013 at pc 0x2, presented only after the second ack;
  - 0x4581 at pc 0x6.
- Backpressure: ready_i=0 for 20 cycles, DEPTH=8 ->
  - level_o saturates at 8 (last push at count 6);
  - mem_req_o=0 while count ≥ 7;
  - no data is lost after ready_i=1.
- Branch to 0x202 while a request is pending and ack is in the same cycle ->
  - the acked word is discarded;
  - next mem_addr_o=0x200;
  - the lower halfword of 0x200 is skipped;
  - the first instruction has pc_o=0x202.
- Wrap-around with DEPTH=4: a compressed instruction at slot 0 offsets all subsequent 32-bit instructions by one slot ->
  - a 32-bit instruction at slots 3/0 is reassembled correctly;
  - level_o never exceeds 4.
- rst_i asserted mid-stream while count=5 ->
  - next cycle: valid_o=0, level_o=0, pc_o=RESET_PC;
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/kmkz_prefetch_buf.sv
// Instruction prefetch buffer: word fetches are split into halfword slots of a
// circular buffer and re-assembled into 16/32-bit instructions for the decoder.
module kmkz_prefetch_buf #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_data_i,
    output logic [31:0]              instr_o,
    output logic                     comp_o,
    output logic [31:0]              pc_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic                     branch_i,
    input  logic [31:0]              branch_pc_i,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [LW-1:0] cnt_t;

    // Two free slots are needed to accept a full word without overflowing.
    localparam cnt_t REQ_MAX = cnt_t'(DEPTH - 2);

    logic [15:0] slots_q [DEPTH];
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_q, skip_d;

    logic        flush;
    logic        push;
    logic        pop;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;
    logic [15:0] head_lo;
    logic [15:0] head_hi;

    // Head decode, handshakes and per-cycle slot counts.
    always_comb begin
        head_lo   = slots_q[rd_ptr_q];
        head_hi   = slots_q[rd_ptr_q + ptr_t'(1)];
        comp_o    = head_lo[1:0] != 2'b11;
        instr_o   = {head_hi, head_lo};
        flush     = rst_i || branch_i;
        mem_req_o = !flush && (count_q <= REQ_MAX);
        push      = mem_req_o && mem_ack_i;
        valid_o   = !flush && ((count_q >= cnt_t'(1) && comp_o) || count_q >= cnt_t'(2));
        pop       = valid_o && ready_i;
        push_n    = push ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        pop_n     = pop ? (comp_o ? 2'd1 : 2'd2) : 2'd0;
    end

    // NOTE: every next-state value gets its hold default first so no path
    // through this block leaves a variable unassigned and infers a latch.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        skip_d       = skip_q;
        count_d      = count_q + cnt_t'(push_n) - cnt_t'(pop_n);

        if (push) begin
            wr_ptr_d     = wr_ptr_q + ptr_t'(push_n);
            fetch_addr_d = fetch_addr_q + 32'd4;
            skip_d       = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(pop_n);
            pc_d     = pc_q + {29'd0, pop_n, 1'b0};
        end

        // A redirect discards anything that arrived or left this cycle.
        if (branch_i) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = branch_pc_i & ~32'd3;
            pc_d         = branch_pc_i & ~32'd1;
            skip_d       = branch_pc_i[1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            pc_q         <= {RESET_PC[31:1], 1'b0};
            skip_q       <= RESET_PC[1];
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            skip_q       <= skip_d;
        end
    end

    // NOTE: the slot array carries no reset; a slot is only read once count
    // says it was written, so clearing it would buy nothing.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (skip_q) begin
                slots_q[wr_ptr_q] <= mem_data_i[31:16];
            end else begin
                slots_q[wr_ptr_q]              <= mem_data_i[15:0];
                slots_q[wr_ptr_q + ptr_t'(1)]  <= mem_data_i[31:16];
            end
        end
    end

    assign mem_addr_o = fetch_addr_q;
    assign pc_o       = pc_q;
    assign level_o    = count_q;

endmodule

// File: tb/tb_kmkz_prefetch_buf.sv
// Scoreboard bench for kmkz_prefetch_buf: directed fetch streams, a small
// instruction-memory image and a monitor that checks every accepted instruction.
module tb_kmkz_prefetch_buf;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] instr;
        logic        comp;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] instr_o;
    logic        comp_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic [$clog2(DEPTH):0] level_o;

    logic        ack_en;
    logic        ack_force;
    logic [31:0] img [256];

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    kmkz_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .instr_o     (instr_o),
        .comp_o      (comp_o),
        .pc_o        (pc_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .branch_i    (branch_i),
        .branch_pc_i (branch_pc_i),
        .level_o     (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory; ack_force models a memory that answers regardless of req.
    assign mem_ack_i  = ack_force | (ack_en & mem_req_o);
    assign mem_data_i = img[mem_addr_o[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic comp, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.comp  = comp;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every handshake against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_comp", {31'd0, comp_o}, {31'd0, e.comp});
                    check("sb_pc", pc_o, e.pc);
                    if (e.comp) check("sb_instr16", {16'd0, instr_o[15:0]}, {16'd0, e.instr[15:0]});
                    else        check("sb_instr32", instr_o, e.instr);
                end
            end
        end
    end

    // Hold ack enabled until n words have been accepted.
    task automatic ack_n(input int n);
        int got = 0;
        int cyc = 0;
        ack_en = 1'b1;
        while (got < n && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_ack_i) got++;
        end
        @(posedge clk);
        #1 ack_en = 1'b0;
        check("ack_count", got, n);
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1 check("drain_level", 32'(level_o), 32'd0);
    endtask

    // Redirect for one cycle; entered and left just after a rising edge.
    task automatic do_branch(input logic [31:0] target, input logic force_ack);
        branch_i    = 1'b1;
        branch_pc_i = target;
        ack_force   = force_ack;
        #1;
        check("br_cycle_req", {31'd0, mem_req_o}, 32'd0);
        check("br_cycle_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk);
        #1;
        branch_i  = 1'b0;
        ack_force = 1'b0;
        #1;
        check("br_pc", pc_o, target & ~32'd1);
        check("br_level", 32'(level_o), 32'd0);
        check("br_valid", {31'd0, valid_o}, 32'd0);
        check("br_req", {31'd0, mem_req_o}, 32'd1);
        check("br_addr", mem_addr_o, target & ~32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 32'h0000_0013;
        // Reset stream at 0x100.
        img[8'h40] = 32'h0001_0013;
        img[8'h41] = 32'h0000_0013;
        img[8'h42] = 32'h0020_0093;
        img[8'h43] = 32'h0030_0113;
        // Mixed stream at 0x0.
        img[8'h00] = 32'h0013_4501;
        img[8'h01] = 32'h4581_0000;
        // Backpressure stream at 0x40, then a word lost to a branch at 0x50.
        for (int k = 0; k < 4; k++) img[8'h10 + k] = 32'h0040_0013 + (32'(k) << 24);
        img[8'h14] = 32'hDEAD_0013;
        // Branch target 0x202: lower half of 0x200 must be skipped.
        img[8'h80] = 32'h0013_1111;
        img[8'h81] = 32'h4501_0000;
        // Wrap stream at 0x300: c.li then 32-bit instructions offset by a slot.
        img[8'hC0] = 32'h0093_4501;
        img[8'hC1] = 32'h0113_1111;
        img[8'hC2] = 32'h0193_2222;
        img[8'hC3] = 32'h0213_3333;
        img[8'hC4] = 32'h0293_4444;
        img[8'hC5] = 32'h4581_5555;

        rst_i       = 1'b1;
        branch_i    = 1'b0;
        branch_pc_i = 32'd0;
        ready_i     = 1'b1;
        ack_en      = 1'b0;
        ack_force   = 1'b0;

        // Reset state and first-fetch latency.
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_pc", pc_o, RESET_PC);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        push_exp(32'h0001_0013, 1'b0, 32'h100);
        push_exp(32'h0000_0013, 1'b0, 32'h104);
        push_exp(32'h0020_0093, 1'b0, 32'h108);
        push_exp(32'h0030_0113, 1'b0, 32'h10C);
        rst_i  = 1'b0;
        ack_en = 1'b1;
        #1;
        check("t1_req", {31'd0, mem_req_o}, 32'd1);
        check("t1_addr0", mem_addr_o, 32'h100);
        check("t1_valid_c1", {31'd0, valid_o}, 32'd0);
        @(posedge clk); #1;
        check("t1_valid_c2", {31'd0, valid_o}, 32'd1);
        check("t1_addr1", mem_addr_o, 32'h104);
        @(posedge clk); #1;
        check("t1_addr2", mem_addr_o, 32'h108);
        @(posedge clk); #1;
        check("t1_addr3", mem_addr_o, 32'h10C);
        @(posedge clk);
        #1 ack_en = 1'b0;
        drain(20);

        // Mixed 16/32-bit stream with a straddle held back until the next ack.
        do_branch(32'h0000_0000, 1'b0);
        push_exp(32'h0000_4501, 1'b1, 32'h0);
        push_exp(32'h0000_0013, 1'b0, 32'h2);
        push_exp(32'h0000_4581, 1'b1, 32'h6);
        ack_n(1);
        @(posedge clk); #1;
        check("t2_straddle_valid_a", {31'd0, valid_o}, 32'd0);
        check("t2_straddle_level", 32'(level_o), 32'd1);
        check("t2_straddle_pc", pc_o, 32'h2);
        check("t2_addr_hold_a", mem_addr_o, 32'h4);
        @(posedge clk); #1;
        check("t2_straddle_valid_b", {31'd0, valid_o}, 32'd0);
        check("t2_addr_hold_b", mem_addr_o, 32'h4);
        ack_n(1);
        drain(20);

        // Decoder backpressure: buffer fills to DEPTH and fetch stops.
        ready_i = 1'b0;
        do_branch(32'h0000_0040, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(32'h0040_0013 + (32'(k) << 24), 1'b0, 32'h40 + 32'(4 * k));
        ack_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("t3_level_max", {31'd0, level_o <= 4'(DEPTH)}, 32'd1);
            check("t3_req_vs_level", {31'd0, mem_req_o}, {31'd0, level_o <= 4'(DEPTH - 2)});
        end
        check("t3_level_full", 32'(level_o), 32'd8);
        check("t3_req_full", {31'd0, mem_req_o}, 32'd0);
        check("t3_addr_full", mem_addr_o, 32'h50);
        ack_en  = 1'b0;
        ready_i = 1'b1;
        drain(20);

        // Branch to a misaligned target while memory acks and a pop is offered.
        ready_i = 1'b0;
        ack_n(1);
        #1 check("t4_level_before", 32'(level_o), 32'd2);
        ready_i = 1'b1;
        do_branch(32'h0000_0203, 1'b1);
        push_exp(32'h0000_0013, 1'b0, 32'h202);
        push_exp(32'h0000_4501, 1'b1, 32'h206);
        ack_n(2);
        drain(20);

        // Pointer wrap with a 32-bit instruction split across slots 7/0.
        do_branch(32'h0000_0300, 1'b0);
        push_exp(32'h0000_4501, 1'b1, 32'h300);
        push_exp(32'h1111_0093, 1'b0, 32'h302);
        push_exp(32'h2222_0113, 1'b0, 32'h306);
        push_exp(32'h3333_0193, 1'b0, 32'h30A);
        push_exp(32'h4444_0213, 1'b0, 32'h30E);
        push_exp(32'h5555_0293, 1'b0, 32'h312);
        push_exp(32'h0000_4581, 1'b1, 32'h316);
        fork
            ack_n(6);
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("t5_level_max", {31'd0, level_o <= 4'(DEPTH)}, 32'd1);
                end
            end
        join
        drain(20);

        // Reset mid-stream with five slots occupied.
        ready_i = 1'b0;
        do_branch(32'h0000_0302, 1'b0);
        ack_n(3);
        #1 check("t6_level_5", 32'(level_o), 32'd5);
        rst_i   = 1'b1;
        ready_i = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, valid_o}, 32'd0);
        check("t6_rst_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        check("t6_level", 32'(level_o), 32'd0);
        check("t6_valid", {31'd0, valid_o}, 32'd0);
        check("t6_pc", pc_o, RESET_PC);
        check("t6_req", {31'd0, mem_req_o}, 32'd1);
        check("t6_addr", mem_addr_o, RESET_PC);
        push_exp(32'h0001_0013, 1'b0, 32'h100);
        ack_n(1);
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
